// File: rtl/wide_alu_pkg.sv
// Shared types, default sizes and the single-cycle result function for the wide ALU responder.
package wide_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_SHRS = 3'd4,
    OP_MUL  = 3'd5,
    OP_ONES = 3'd6,
    OP_NONE = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_IT  = 2'd1,
    ST_ONES_IT = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam int DEF_W     = 512;
  localparam int DEF_CHUNK = 32;
  localparam int DEF_TAG_W = 4;

  // Widest operand the helper handles; narrower instances pass zero-extended operands and a width mask.
  localparam int ALU_W = DEF_W;

  function automatic logic [ALU_W-1:0] simple_result(
    input op_t              op,
    input logic [ALU_W-1:0] a,
    input logic [ALU_W-1:0] b,
    input logic [15:0]      sh,
    input logic             sign,
    input logic [ALU_W-1:0] mask
  );
    logic [ALU_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SHL:  r = a << sh;
      OP_SHR:  r = a >> sh;
      // Fill the vacated top bits of the active width with the sign bit.
      OP_SHRS: r = (a >> sh) | (sign ? (mask & ~(mask >> sh)) : '0);
      default: r = '0;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/wide_alu_iter.sv
// Chunk-serial engine: MUL accumulates rs1 times one CHUNK slice of rs2 per cycle, ONES counts one slice per cycle.
module wide_alu_iter
  import wide_alu_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  output logic         done,
  output logic [W-1:0] result
);
  localparam int N     = W / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(CHUNK + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic             busy;
  logic             mode_q;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] ones;
  logic [W-1:0]     term;

  // Operands are shifted each cycle so the active slice always sits at bit 0 (rs1 moves up for MUL).
  always_comb begin
    ones = '0;
    for (int i = 0; i < CHUNK; i++) begin
      ones = ones + CNT_W'(a_q[i]);
    end
    if (mode_q) term = W'(ones);
    else        term = a_q * W'(b_q[CHUNK-1:0]);
  end

  assign result = acc + term;
  assign done   = busy && (idx == LAST);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      busy   <= 1'b0;
      mode_q <= 1'b0;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mode_q <= mode;
      idx    <= '0;
      a_q    <= rs1;
      b_q    <= rs2;
      acc    <= '0;
    end else if (busy) begin
      acc <= result;
      idx <= idx + IDX_W'(1);
      a_q <= mode_q ? (a_q >> CHUNK) : (a_q << CHUNK);
      b_q <= b_q >> CHUNK;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/wide_alu_responder.sv
// Valid/ready request/response server for wide integer ops; owns the FSM, tag, response register and ops counter.
module wide_alu_responder
  import wide_alu_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CHUNK = DEF_CHUNK,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             req_valid,
  output logic             req_ready,
  input  op_t              req_op,
  input  logic [W-1:0]     req_rs1,
  input  logic [W-1:0]     req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      ops_done
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; valid holds, with its payload
  // stable, until that edge. req_ready in RESP mirrors rsp_ready so a new request can ride the response handshake.
  localparam int SH_W = $clog2(W);
  localparam logic [ALU_W-1:0] W_MASK = {ALU_W{1'b1}} >> (ALU_W - W);

  state_t           state, state_d;
  logic             accept;
  logic             rsp_fire;
  logic             is_iter;
  logic             iter_done;
  logic [W-1:0]     iter_result;
  logic [ALU_W-1:0] simple_full;
  logic [W-1:0]     simple_data;
  logic [W-1:0]     rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_d;
  logic [31:0]      ops_done_d;

  assign req_ready = !arst && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign is_iter   = (req_op == OP_MUL) || (req_op == OP_ONES);

  assign simple_full = simple_result(req_op, ALU_W'(req_rs1), ALU_W'(req_rs2),
                                     16'(req_rs2[SH_W-1:0]), req_rs1[W-1], W_MASK);
  assign simple_data = W'(simple_full);

  wide_alu_iter #(.W(W), .CHUNK(CHUNK)) u_iter (
    .clk    (clk),
    .arst   (arst),
    .start  (accept && is_iter),
    .mode   (req_op == OP_ONES),
    .rs1    (req_rs1),
    .rs2    (req_rs2),
    .done   (iter_done),
    .result (iter_result)
  );

  always_comb begin
    state_d    = state;
    rsp_data_d = rsp_data;
    rsp_tag_d  = rsp_tag;
    ops_done_d = ops_done;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (rsp_fire) begin
          ops_done_d = ops_done + 32'd1;
          state_d    = ST_IDLE;
        end
        if (accept) begin
          rsp_tag_d = req_tag;
          if (req_op == OP_MUL) begin
            state_d = ST_MUL_IT;
          end else if (req_op == OP_ONES) begin
            state_d = ST_ONES_IT;
          end else begin
            rsp_data_d = simple_data;
            state_d    = ST_RESP;
          end
        end
      end
      ST_MUL_IT, ST_ONES_IT: begin
        if (iter_done) begin
          rsp_data_d = iter_result;
          state_d    = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= ST_IDLE;
      rsp_data <= '0;
      rsp_tag  <= '0;
      ops_done <= '0;
    end else begin
      state    <= state_d;
      rsp_data <= rsp_data_d;
      rsp_tag  <= rsp_tag_d;
      ops_done <= ops_done_d;
    end
  end

endmodule

// File: tb/tb_wide_alu_responder.sv
// Scoreboard bench for wide_alu_responder: directed latency/backpressure/reset cases plus randomized traffic.
module tb_wide_alu_responder;
  import wide_alu_pkg::*;

  localparam int W     = 512;
  localparam int CHUNK = 32;
  localparam int TAG_W = 4;
  localparam int N     = W / CHUNK;
  localparam int SH_W  = $clog2(W);

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  op_t              req_op = OP_NONE;
  logic [W-1:0]     req_rs1 = '0;
  logic [W-1:0]     req_rs2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      ops_done;

  int checks = 0;
  int errors = 0;
  logic [W+TAG_W-1:0] exp_q[$];
  logic [31:0] ops_model = '0;

  logic bp_mode = 1'b0;
  logic rsp_ready_cmd = 1'b1;
  logic rnd_ready = 1'b1;

  assign rsp_ready = bp_mode ? rnd_ready : rsp_ready_cmd;

  wide_alu_responder #(.W(W), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .arst      (arst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .ops_done  (ops_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'(b[SH_W-1:0]);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SHL:  return a << s;
      OP_SHR:  return a >> s;
      OP_SHRS: return $unsigned($signed(a) >>> s);
      OP_MUL:  return a * b;
      OP_ONES: return W'($countones(a));
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_wide();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered just after a rising edge; returns just after the edge that accepted the request.
  task automatic issue(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: op %0d not accepted after %0d cycles", op, n);
    end else begin
      exp_q.push_back({ref_model(op, a, b), tag});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called right after the accepting edge of a MUL/ONES request with rsp_ready high.
  task automatic wait_iter(input string name);
    for (int k = 0; k < N; k++) begin
      check({name, "_busy_valid"}, rsp_valid, 1'b0);
      check({name, "_busy_ready"}, req_ready, 1'b0);
      step(1);
    end
    check({name, "_valid_at_latency"}, rsp_valid, 1'b1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic             stall_v = 1'b0;
  logic [W-1:0]     stall_d;
  logic [TAG_W-1:0] stall_t;

  always @(negedge clk) begin
    logic [W+TAG_W-1:0] e;
    if (arst) begin
      stall_v = 1'b0;
      ops_model = '0;
      exp_q.delete();
    end else begin
      if (stall_v) begin
        check("rsp_hold_valid", rsp_valid, 1'b1);
        if (rsp_valid) begin
          check("rsp_hold_data", rsp_data, stall_d);
          check("rsp_hold_tag", rsp_tag, stall_t);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: data %h tag %0d with empty expected queue", rsp_data, rsp_tag);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e[W+TAG_W-1:TAG_W]);
          check("rsp_tag", rsp_tag, e[TAG_W-1:0]);
        end
        ops_model = ops_model + 32'd1;
        stall_v = 1'b0;
      end else if (rsp_valid) begin
        stall_v = 1'b1;
        stall_d = rsp_data;
        stall_t = rsp_tag;
      end else begin
        stall_v = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] v;
    logic [31:0]  ops_before;
    op_t          op;
    int           n;

    // Reset state
    #1;
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_req_ready", req_ready, 1'b0);
    check("reset_rsp_data", rsp_data, '0);
    check("reset_ops_done", ops_done, '0);
    step(3);
    arst = 1'b0;
    #1;
    check("release_req_ready", req_ready, 1'b1);
    step(1);

    // ADD latency 1
    rsp_ready_cmd = 1'b1;
    issue(OP_ADD, W'(5), W'(3), 4'd2);
    check("add_valid_latency", rsp_valid, 1'b1);
    check("add_data", rsp_data, W'(8));
    check("add_tag", rsp_tag, W'(2));
    step(1);
    check("add_ops_done", ops_done, W'(1));

    // SUB then SHRS issued on the handshake cycle
    issue(OP_SUB, '0, W'(1), 4'd3);
    check("sub_data", rsp_data, {W{1'b1}});
    a = '0;
    a[W-1] = 1'b1;
    issue(OP_SHRS, a, W'(4), 4'd4);
    v = '0;
    v[W-1 -: 5] = 5'h1f;
    check("b2b_no_idle", rsp_valid, 1'b1);
    check("shrs_data", rsp_data, v);
    check("b2b_ops_done", ops_done, W'(2));
    step(1);

    // MUL latency and value
    a = (W'(1) << 32) + W'(1);
    issue(OP_MUL, a, a, 4'd5);
    wait_iter("mul");
    v = (W'(1) << 64) + (W'(1) << 33) + W'(1);
    check("mul_data", rsp_data, v);
    check("mul_tag", rsp_tag, W'(5));
    step(1);

    // ONES
    issue(OP_ONES, {W{1'b1}}, rnd_wide(), 4'd6);
    wait_iter("ones_all");
    check("ones_all_data", rsp_data, W'(16'h200));
    step(1);
    a = (W'(1) << 170) | W'(4'hf);
    issue(OP_ONES, a, '0, 4'd7);
    wait_iter("ones_sparse");
    check("ones_sparse_data", rsp_data, W'(5));
    step(1);

    // Boundary shifts and wraparound (checked by the scoreboard)
    issue(OP_ADD, {W{1'b1}}, W'(1), 4'd8);
    issue(OP_SHL, rnd_wide(), '0, 4'd9);
    issue(OP_SHR, rnd_wide(), {{(W-SH_W){1'b1}}, {SH_W{1'b1}}}, 4'd10);
    issue(OP_SHRS, {W{1'b1}} >> 1, W'(W - 1), 4'd11);
    issue(OP_SHRS, ~({W{1'b1}} >> 1), W'(W - 1), 4'd12);
    issue(OP_NONE, rnd_wide(), rnd_wide(), 4'd13);
    step(2);
    check("ops_done_after_directed", ops_done, ops_model);

    // Backpressure: response held while new requests wait
    rsp_ready_cmd = 1'b0;
    issue(OP_ADD, W'(100), W'(23), 4'd14);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_op    = op_t'(3'($urandom_range(0, 4)));
      req_rs1   = rnd_wide();
      req_rs2   = rnd_wide();
      req_tag   = 4'($urandom_range(0, 15));
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      step(1);
    end
    check("bp_data", rsp_data, W'(123));
    ops_before = ops_done;
    rsp_ready_cmd = 1'b1;
    issue(OP_ADD, W'(7), W'(9), 4'd15);
    check("bp_accept_on_handshake", ops_done, W'(ops_before + 32'd1));
    check("bp_second_data", rsp_data, W'(16));
    step(2);

    // Reset mid-MUL
    issue(OP_MUL, rnd_wide(), rnd_wide(), 4'd1);
    step(7);
    arst = 1'b1;
    #1;
    check("rst_mul_rsp_valid", rsp_valid, 1'b0);
    check("rst_mul_req_ready", req_ready, 1'b0);
    check("rst_mul_ops_done", ops_done, '0);
    step(2);
    arst = 1'b0;
    #1;
    check("rst_release_req_ready", req_ready, 1'b1);
    for (int k = 0; k < N + 2; k++) begin
      check("rst_no_stale_rsp", rsp_valid, 1'b0);
      step(1);
    end
    issue(OP_ADD, W'(1), W'(1), 4'd2);
    check("rst_add_data", rsp_data, W'(2));
    step(1);
    check("rst_ops_done", ops_done, W'(1));

    // Reset during a stalled response
    rsp_ready_cmd = 1'b0;
    issue(OP_SUB, W'(9), W'(4), 4'd3);
    step(2);
    arst = 1'b1;
    #1;
    check("rst_resp_rsp_valid", rsp_valid, 1'b0);
    check("rst_resp_ops_done", ops_done, '0);
    step(2);
    arst = 1'b0;
    rsp_ready_cmd = 1'b1;
    step(3);
    check("rst_resp_no_rsp", rsp_valid, 1'b0);

    // Randomized traffic with random backpressure
    bp_mode = 1'b1;
    repeat (60) begin
      op = op_t'(3'($urandom_range(0, 7)));
      a = rnd_wide();
      b = rnd_wide();
      if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, W - 1));
      if ($urandom_range(0, 7) == 0) a = '0;
      issue(op, a, b, 4'($urandom_range(0, 15)));
      step($urandom_range(0, 2));
    end
    bp_mode = 1'b0;
    rsp_ready_cmd = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    check("drain_queue_empty", W'(exp_q.size()), '0);
    step(2);
    check("final_ops_done", ops_done, ops_model);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wide_alu_responder.md
Name: wide_alu_responder

Overview:
- Sequential request/response server for wide-operand integer operations: add, sub, shl, shr, shrs, mul, popcount.
- Answers an initiator that issues `{op, rs1, rs2, tag}` over a valid/ready request channel and consumes results over a valid/ready response channel.
- Simple ops complete in one cycle.
- MUL and ONES are iterative: one CHUNK-bit slice per cycle, which keeps the wide multiply off the critical path.

Parameters:
- W, 512, operand/result width; multiple of CHUNK.
- CHUNK, 32, bits processed per iteration cycle for MUL/ONES.
- TAG_W, 4, width of request tag echoed on the response.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  responder can accept a request.
- req_op  in  3  operation, wide_alu_pkg::op_t.
- req_rs1  in  W  operand 1.
- req_rs2  in  W  operand 2.
- req_tag  in  TAG_W  request tag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  W  result.
- rsp_tag  out  TAG_W  tag of the answered request.
- ops_done  out  32  count of completed response handshakes.

Behaviour:
- Reset (arst high, async):
  - state=IDLE; rsp_valid=0, rsp_data=0, rsp_tag=0, ops_done=0; internal accumulator, chunk index and operands cleared.
  - req_ready=0 while arst is high; req_ready=1 from the first cycle after release.
- Op encoding: ADD=0, SUB=1, SHL=2, SHR=3, SHRS=4, MUL=5, ONES=6, NONE=7.
- Arithmetic (all results W bits; overflow wraps mod 2^W; no flags):
  - Shift amount = rs2[$clog2(W)-1:0]; upper rs2 bits are ignored.
  - SHRS replicates rs1[W-1].
  - MUL returns the low W bits of rs1*rs2.
  - ONES returns the population count of rs1, zero-extended to W.
  - NONE returns 0.
- States: IDLE, MUL_IT, ONES_IT, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid&&req_ready at edge E0.
  - ADD/SUB/SHL/SHR/SHRS/NONE: result computed from the request inputs, registered at E0 into rsp_data/rsp_tag, state->RESP. rsp_valid is visible the cycle after E0 (latency 1).
  - MUL/ONES: rs1, rs2 and tag latched at E0; accumulator=0; idx=0; state->MUL_IT or ONES_IT.
- MUL_IT:
  - Each edge: acc += (rs1 * rs2[idx*CHUNK +: CHUNK]) << (idx*CHUNK), truncated to W; idx++.
  - On the edge processing idx=W/CHUNK-1: rsp_data=final acc, state->RESP.
  - rsp_valid rises at edge E0+W/CHUNK (16 cycles at defaults).
- ONES_IT:
  - Each edge: acc += popcount(rs1[idx*CHUNK +: CHUNK]).
  - Same idx sequencing and latency as MUL_IT.
- RESP:
  - rsp_valid=1; rsp_data and rsp_tag held stable until handshake.
  - On rsp_valid&&rsp_ready: ops_done++ (wraps at 2^32) and state->IDLE.
  - req_ready = rsp_ready in RESP, giving back-to-back throughput. A request accepted in the same cycle as the response handshake is processed exactly as from IDLE (single-cycle op: rsp_valid stays high with new data next cycle).
- req_ready=0 in MUL_IT/ONES_IT; req_* inputs are ignored there and may change freely.
- rsp_valid never deasserts without a handshake except on arst.
- arst mid-iteration or mid-RESP aborts: no response is produced, ops_done=0, and the pending tag is lost.
- Out-of-range op values (none exist with 3 bits) are treated as NONE.

Decomposition:
- Package wide_alu_pkg holds:
  - op_t enum (3-bit, encodings above);
  - default W and CHUNK localparams;
  - a function computing single-cycle results (add/sub/shl/shr/shrs/none).
- One sub-module, wide_alu_iter: the MUL/ONES chunk engine with interface start, mode, rs1, rs2 -> done, result.
- The top module owns the FSM, handshakes, tag and ops_done.

Test Plan:
1. ADD rs1=5, rs2=3, tag=2, rsp_ready=1 -> rsp_valid the cycle after accept; data=8, tag=2; ops_done=1.
2. SUB rs1=0, rs2=1 -> data = all W bits 1. Back-to-back with SHRS rs1=1<<511, rs2=4, issued in the handshake cycle -> next response data = 5 MSBs set, rest 0; no idle cycle between responses.
3. MUL rs1=2^32+1, rs2=2^32+1 -> req_ready low for 16 cycles; rsp_valid at accept+16; data = 2^64+2^33+1.
4. ONES rs1=all ones -> data=0x200 at accept+16. ONES rs1=0x171-bit pattern {0x1, 0xF} -> data=5.
5. Backpressure: ADD with rsp_ready=0 for 5 cycles, while req_valid stays high with new operands -> rsp_valid, data and tag stable; req_ready=0; second request accepted only in the handshake cycle.
6. Reset mid-MUL: assert arst at iteration 7 -> rsp_valid=0 and req_ready=0 immediately; after release req_ready=1, no stale response, ops_done=0. A subsequent ADD 1+1 returns 2.
